// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared receiver state encoding and bit-timing helper
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_rd, do_wr;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // storage array; contents need no reset because empty masks the read port
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_rd ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a byte FIFO with sticky error flags and irq
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = 16000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_uart,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       irq_rx,
    output logic       overrun,
    output logic       frame_err,
    input  logic       clear_err
);

    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    rx_state_t     state, state_n;
    logic [1:0]    sync;
    logic          rx, rx_prev;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          push, ferr_set, ovf_set, full, empty;

    assign rx       = sync[1];
    assign rd_valid = ~empty;
    assign ovf_set  = push & full & ~(rd_en & rd_valid);

    // synchroniser, edge history and receiver datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
        end else begin
            sync    <= {sync[0], rx_uart};
            rx_prev <= rx;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
        end
    end

    // frame FSM: start qualified at half bit, data and stop sampled a full bit later each
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        idx_n    = idx;
        shift_n  = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n   = '0;
                state_n = (rx_prev & ~rx) ? ST_START : ST_IDLE;
            end
            ST_START: if (cnt == CW'(HALF - 1)) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rx ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (cnt == CW'(CPB - 1)) begin
                cnt_n        = '0;
                shift_n[idx] = rx;
                idx_n        = idx + 3'd1;
                state_n      = (idx == 3'd7) ? ST_STOP : ST_DATA;
            end
            ST_STOP: if (cnt == CW'(CPB - 1)) begin
                cnt_n    = '0;
                push     = rx;
                ferr_set = ~rx;
                state_n  = rx ? ST_IDLE : ST_BRK;
            end
            ST_BRK: begin
                cnt_n   = '0;
                state_n = rx ? ST_IDLE : ST_BRK;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // sticky errors where a new event beats a simultaneous clear; irq lags rd_valid by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_rx    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            irq_rx    <= rd_valid;
            overrun   <= ovf_set | (overrun & ~clear_err);
            frame_err <= ferr_set | (frame_err & ~clear_err);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (shift),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

endmodule
